// File: rtl/sync_timing_detect.sv
// sync_timing_detect
// Measures incoming video timing from hSync / vSync / DE and publishes it once
// two consecutive frames produce the same measurement.
//
// Ports:
//   clock      - single rising-edge clock
//   reset      - asynchronous active-high reset
//   hSyncIn    - horizontal sync, active high
//   vSyncIn    - vertical sync, active high
//   deIn       - data enable (active pixel), active high
//   hTotal     - clocks per line        (hBusWidth)
//   hActive    - active pixels per line (hBusWidth)
//   vTotal     - lines per frame        (busWidth)
//   vActive    - active lines per frame (busWidth)
//   locked     - high while the measured timing is stable
//   frameStart - one-cycle pulse per detected vSync rising edge
module sync_timing_detect #(
  parameter int busWidth  = 11,
  parameter int hBusWidth = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 hSyncIn,
  input  logic                 vSyncIn,
  input  logic                 deIn,
  output logic [hBusWidth-1:0] hTotal,
  output logic [hBusWidth-1:0] hActive,
  output logic [busWidth-1:0]  vTotal,
  output logic [busWidth-1:0]  vActive,
  output logic                 locked,
  output logic                 frameStart
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef struct packed {
    logic [hBusWidth-1:0] h_total;
    logic [hBusWidth-1:0] h_active;
    logic [busWidth-1:0]  v_total;
    logic [busWidth-1:0]  v_active;
  } cand_t;

  localparam logic [hBusWidth-1:0] H_MAX  = {hBusWidth{1'b1}};
  localparam logic [hBusWidth-1:0] H_ZERO = {hBusWidth{1'b0}};
  localparam logic [hBusWidth-1:0] H_ONE  = {{(hBusWidth-1){1'b0}}, 1'b1};
  localparam logic [busWidth-1:0]  V_MAX  = {busWidth{1'b1}};
  localparam logic [busWidth-1:0]  V_ZERO = {busWidth{1'b0}};
  localparam logic [busWidth-1:0]  V_ONE  = {{(busWidth-1){1'b0}}, 1'b1};
  localparam cand_t                C_ZERO = '0;

  // Input pipeline: one register stage, one delayed copy, registered edge flags.
  // DE is delayed by the same amount so it lines up with the edge flags.
  logic hs_r, vs_r, de_r;
  logic hs_d_r, vs_d_r, de_d_r;
  logic hs_edge_r, vs_edge_r;

  logic [hBusWidth-1:0] h_count_r, de_count_r, line_len_r, max_act_r;
  logic [busWidth-1:0]  line_count_r, act_lines_r;
  state_t               state_r;
  cand_t                prev_r;

  logic [hBusWidth-1:0] line_len_s, max_act_s;
  logic [busWidth-1:0]  line_count_s, act_lines_s;
  cand_t                cand_s;
  logic                 cand_ok_s;
  logic                 h_sat_s;

  // Input registers and rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_r      <= 1'b0;
      vs_r      <= 1'b0;
      de_r      <= 1'b0;
      hs_d_r    <= 1'b0;
      vs_d_r    <= 1'b0;
      de_d_r    <= 1'b0;
      hs_edge_r <= 1'b0;
      vs_edge_r <= 1'b0;
    end else begin
      hs_r      <= hSyncIn;
      vs_r      <= vSyncIn;
      de_r      <= deIn;
      hs_d_r    <= hs_r;
      vs_d_r    <= vs_r;
      de_d_r    <= de_r;
      hs_edge_r <= hs_r & ~hs_d_r;
      vs_edge_r <= vs_r & ~vs_d_r;
    end
  end

  // Frame accumulators as they stand after this cycle's hSync edge, so a
  // coincident vSync edge sees the closing line already included
  always_comb begin
    line_len_s   = line_len_r;
    line_count_s = line_count_r;
    act_lines_s  = act_lines_r;
    max_act_s    = max_act_r;
    if (hs_edge_r) begin
      line_len_s = h_count_r;
      if (line_count_r != V_MAX) begin
        line_count_s = line_count_r + V_ONE;
      end else begin
        line_count_s = line_count_r;
      end
      if ((de_count_r != H_ZERO) && (act_lines_r != V_MAX)) begin
        act_lines_s = act_lines_r + V_ONE;
      end else begin
        act_lines_s = act_lines_r;
      end
      if (de_count_r > max_act_r) begin
        max_act_s = de_count_r;
      end else begin
        max_act_s = max_act_r;
      end
    end else begin
      line_len_s = line_len_r;
    end
  end

  // Candidate formation; a saturated field means the measurement overflowed
  always_comb begin
    cand_s.h_total  = line_len_s;
    cand_s.h_active = max_act_s;
    cand_s.v_total  = line_count_s;
    cand_s.v_active = act_lines_s;
    cand_ok_s = (cand_s != C_ZERO) &&
                (line_len_s != H_MAX) && (max_act_s != H_MAX) &&
                (line_count_s != V_MAX) && (act_lines_s != V_MAX);
    h_sat_s = (h_count_r == H_MAX) && !hs_edge_r;
  end

  // Line and frame counters, all saturating
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_count_r    <= H_ZERO;
      de_count_r   <= H_ZERO;
      line_len_r   <= H_ZERO;
      max_act_r    <= H_ZERO;
      line_count_r <= V_ZERO;
      act_lines_r  <= V_ZERO;
    end else begin
      if (hs_edge_r) begin
        h_count_r  <= H_ONE;
        de_count_r <= de_d_r ? H_ONE : H_ZERO;
      end else begin
        if (h_count_r != H_MAX) begin
          h_count_r <= h_count_r + H_ONE;
        end
        if (de_d_r && (de_count_r != H_MAX)) begin
          de_count_r <= de_count_r + H_ONE;
        end
      end
      line_len_r <= line_len_s;
      if (vs_edge_r) begin
        line_count_r <= V_ZERO;
        act_lines_r  <= V_ZERO;
        max_act_r    <= H_ZERO;
      end else begin
        line_count_r <= line_count_s;
        act_lines_r  <= act_lines_s;
        max_act_r    <= max_act_s;
      end
    end
  end

  // Lock state machine with registered timing outputs; a missing hSync
  // (hCount saturated) overrides any vSync decision in the same cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= SEARCH;
      prev_r     <= C_ZERO;
      hTotal     <= H_ZERO;
      hActive    <= H_ZERO;
      vTotal     <= V_ZERO;
      vActive    <= V_ZERO;
      locked     <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      frameStart <= vs_edge_r;
      if (h_sat_s) begin
        state_r <= SEARCH;
        prev_r  <= C_ZERO;
        locked  <= 1'b0;
      end else if (vs_edge_r) begin
        case (state_r)
          SEARCH: begin
            state_r <= MEASURE;
            locked  <= 1'b0;
          end
          MEASURE: begin
            if (cand_ok_s && (cand_s == prev_r)) begin
              state_r <= LOCKED;
              locked  <= 1'b1;
              hTotal  <= cand_s.h_total;
              hActive <= cand_s.h_active;
              vTotal  <= cand_s.v_total;
              vActive <= cand_s.v_active;
            end else begin
              state_r <= MEASURE;
              prev_r  <= cand_s;
              locked  <= 1'b0;
            end
          end
          LOCKED: begin
            if (cand_ok_s && (cand_s == prev_r)) begin
              state_r <= LOCKED;
              locked  <= 1'b1;
            end else begin
              state_r <= MEASURE;
              prev_r  <= cand_s;
              locked  <= 1'b0;
            end
          end
          default: begin
            state_r <= SEARCH;
            prev_r  <= C_ZERO;
            locked  <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
        locked  <= locked;
      end
    end
  end

endmodule

// File: tb/tb_sync_timing_detect.sv
// tb_sync_timing_detect
// Drives sync_timing_detect with generated video frames, hand-built corner
// sequences and randomized timings; every cycle is compared against a
// frame-level reference model, and selected points against fixed tables.
module tb_sync_timing_detect;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hSyncIn = 1'b0;
  logic        vSyncIn = 1'b0;
  logic        deIn = 1'b0;
  logic [11:0] hTotal, hActive;
  logic [10:0] vTotal, vActive;
  logic        locked, frameStart;

  int checks = 0;
  int failures = 0;

  sync_timing_detect #(.busWidth(11), .hBusWidth(12)) dut (
    .clock(clock), .reset(reset), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
    .deIn(deIn), .hTotal(hTotal), .hActive(hActive), .vTotal(vTotal),
    .vActive(vActive), .locked(locked), .frameStart(frameStart)
  );

  always #5 clock = ~clock;

  typedef struct { int ht; int ha; int vt; int va; } cand_t;
  typedef struct { bit lk; bit fs; int ht; int ha; int vt; int va; } exp_t;
  typedef struct {
    bit rst; int hl; int dl; int ln; int al; int nf;
    bit lk; int ht; int ha; int vt; int va;
  } row_t;

  // Reference model: pin-level events grouped into lines and frames
  bit    m_search, m_locked, m_prev_hs, m_prev_vs;
  cand_t m_prev;
  int    m_ht, m_ha, m_vt, m_va;
  int    m_idx, m_last_hs, m_last_len, m_de_sum;
  int    m_acts[$];
  exp_t  d1, d2;

  function automatic logic [63:0] pack(input exp_t e);
    logic [11:0] a, b;
    logic [10:0] c, d;
    a = e.ht[11:0]; b = e.ha[11:0]; c = e.vt[10:0]; d = e.va[10:0];
    return {16'd0, e.lk, e.fs, a, b, c, d};
  endfunction

  function automatic logic [63:0] dut_pack();
    return {16'd0, locked, frameStart, hTotal, hActive, vTotal, vActive};
  endfunction

  function automatic exp_t mk(input bit lk, input int ht, input int ha, input int vt, input int va);
    exp_t e;
    e.lk = lk; e.fs = 1'b0; e.ht = ht; e.ha = ha; e.vt = vt; e.va = va;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (lk fs ht ha vt va packed)", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_search = 1'b1; m_locked = 1'b0; m_prev_hs = 1'b0; m_prev_vs = 1'b0;
    m_prev = '{0, 0, 0, 0};
    m_ht = 0; m_ha = 0; m_vt = 0; m_va = 0;
    m_idx = 0; m_last_hs = -2; m_last_len = 0; m_de_sum = 0;
    m_acts.delete();
    d1 = mk(1'b0, 0, 0, 0, 0);
    d2 = mk(1'b0, 0, 0, 0, 0);
  endtask

  task automatic model_step(input bit hs, input bit vs, input bit de, output exp_t e);
    bit hr, vr, stall, valid, same;
    cand_t c;
    int mx, nz, len;
    hr = hs && !m_prev_hs;
    vr = vs && !m_prev_vs;
    if (hr) begin
      len = m_idx - m_last_hs;
      m_last_len = (len > 4095) ? 4095 : len;
      m_acts.push_back((m_de_sum > 4095) ? 4095 : m_de_sum);
      m_last_hs = m_idx;
      m_de_sum = de ? 1 : 0;
    end else begin
      m_de_sum += de ? 1 : 0;
    end
    stall = !hr && ((m_idx - m_last_hs) >= 4095);
    c = '{0, 0, 0, 0};
    if (vr) begin
      mx = 0; nz = 0;
      foreach (m_acts[k]) begin
        if (m_acts[k] > mx) mx = m_acts[k];
        if (m_acts[k] != 0) nz++;
      end
      c.ht = m_last_len;
      c.ha = mx;
      c.vt = (m_acts.size() > 2047) ? 2047 : m_acts.size();
      c.va = (nz > 2047) ? 2047 : nz;
      m_acts.delete();
    end
    valid = (c.ht != 4095) && (c.ha != 4095) && (c.vt != 2047) && (c.va != 2047) &&
            ((c.ht | c.ha | c.vt | c.va) != 0);
    same = (c.ht == m_prev.ht) && (c.ha == m_prev.ha) && (c.vt == m_prev.vt) && (c.va == m_prev.va);
    if (stall) begin
      m_search = 1'b1; m_locked = 1'b0; m_prev = '{0, 0, 0, 0};
    end else if (vr) begin
      if (m_search) begin
        m_search = 1'b0;
      end else if (valid && same) begin
        if (!m_locked) begin
          m_ht = c.ht; m_ha = c.ha; m_vt = c.vt; m_va = c.va;
        end
        m_locked = 1'b1;
      end else begin
        m_locked = 1'b0;
        m_prev = c;
      end
    end
    m_prev_hs = hs; m_prev_vs = vs; m_idx++;
    e = mk(m_locked, m_ht, m_ha, m_vt, m_va);
    e.fs = vr;
  endtask

  // One clock: drive pins, advance model, compare the outputs due now
  task automatic step(input bit hs, input bit vs, input bit de);
    exp_t e, c;
    hSyncIn = hs; vSyncIn = vs; deIn = de;
    model_step(hs, vs, de, e);
    @(posedge clock); #1;
    c = d2; d2 = d1; d1 = e;
    if (failures < 40) check("stream", dut_pack(), pack(c));
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1; hSyncIn = 1'b0; vSyncIn = 1'b0; deIn = 1'b0;
    #1 check(name, dut_pack(), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic frame_part(input int hl, input int dl, input int al, input int vo, input int nl);
    for (int l = 0; l < nl; l++)
      for (int c = 0; c < hl; c++)
        step(c < 2, (l == 0) && (c >= vo) && (c < vo + 3),
             (l >= 1) && (l <= al) && (c >= 4) && (c < 4 + dl));
  endtask

  task automatic frame(input int hl, input int dl, input int ln, input int al);
    frame_part(hl, dl, al, 0, ln);
  endtask

  row_t rows[7];

  initial begin
    // A candidate describes the frame closed by a vSync edge, so a timing
    // change shows up one frame after it is applied.
    rows[0] = '{1'b1, 20, 12, 10, 6, 3, 1'b1, 20, 12, 10, 6};
    rows[1] = '{1'b0, 20, 10, 10, 6, 1, 1'b1, 20, 12, 10, 6};
    rows[2] = '{1'b0, 20, 10, 10, 6, 1, 1'b0, 20, 12, 10, 6};
    rows[3] = '{1'b0, 20, 10, 10, 6, 1, 1'b1, 20, 10, 10, 6};
    rows[4] = '{1'b0, 32, 16, 8, 5, 1, 1'b1, 20, 10, 10, 6};
    rows[5] = '{1'b0, 32, 16, 8, 5, 1, 1'b0, 20, 10, 10, 6};
    rows[6] = '{1'b0, 32, 16, 8, 5, 1, 1'b1, 32, 16, 8, 5};

    model_reset();
    #2;
    for (int r = 0; r < 7; r++) begin
      if (rows[r].rst) do_reset("reset_state");
      for (int f = 0; f < rows[r].nf; f++)
        frame(rows[r].hl, rows[r].dl, rows[r].ln, rows[r].al);
      check($sformatf("row%0d", r), dut_pack(),
            pack(mk(rows[r].lk, rows[r].ht, rows[r].ha, rows[r].vt, rows[r].va)));
    end

    // Reset mid-frame while locked clears everything without a clock edge
    frame_part(20, 12, 6, 0, 3);
    #3;
    do_reset("async_reset");
    frame(20, 12, 10, 6);
    check("first_frame_no_lock", dut_pack(), pack(mk(1'b0, 0, 0, 0, 0)));
    frame(20, 12, 10, 6);
    frame(20, 12, 10, 6);
    check("relock_after_reset", dut_pack(), pack(mk(1'b1, 20, 12, 10, 6)));

    // hSync stopped long enough to saturate hCount
    for (int i = 0; i < 4100; i++) step(1'b0, 1'b0, 1'b0);
    check("stall_unlock", dut_pack(), pack(mk(1'b0, 20, 12, 10, 6)));
    frame(20, 12, 10, 6);
    frame(20, 12, 10, 6);
    check("resume_two_edges", dut_pack(), pack(mk(1'b0, 20, 12, 10, 6)));
    frame(20, 12, 10, 6);
    check("resume_relock", dut_pack(), pack(mk(1'b1, 20, 12, 10, 6)));

    // Lines longer than the horizontal counter can hold never lock
    for (int f = 0; f < 4; f++) begin
      frame(4100, 12, 2, 1);
      check($sformatf("sat_no_lock%0d", f), dut_pack(), pack(mk(1'b0, 20, 12, 10, 6)));
    end

    // Randomized timings, vSync offsets and short bursts of noise
    for (int t = 0; t < 14; t++) begin
      int hl, dl, ln, al, nf, vo, nn;
      hl = $urandom_range(16, 40);
      dl = $urandom_range(1, hl - 6);
      ln = $urandom_range(3, 12);
      al = $urandom_range(1, ln - 1);
      nf = $urandom_range(1, 4);
      vo = $urandom_range(0, 5);
      for (int f = 0; f < nf; f++) frame_part(hl, dl, al, vo, ln);
      nn = $urandom_range(0, 3);
      if (nn == 0) begin
        for (int i = 0; i < 25; i++)
          step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    for (int i = 0; i < 3; i++) frame(24, 14, 7, 4);
    check("random_tail_lock", dut_pack(), pack(mk(1'b1, 24, 14, 7, 4)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
